spi_master_cmd: RTL and testbench
=================================

SPI_MASTER_CMD -- requirements
Module: spi_master_cmd

Interface
REQ-001 The block SHALL have parameter TURNAROUND, default 2: cycles between the last MOSI bit and the first MISO sample of a read-data frame; legal range 1..15.
REQ-002 The block SHALL have parameter GAP, default 1: minimum cycles SS_n is held high between frames; legal range 1..15.
REQ-003 The block SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-004 The block SHALL have port rst  in  1  synchronous active-high reset.
REQ-005 The block SHALL have port req_valid  in  1  command request present.
REQ-006 The block SHALL have port req_ready  out  1  block can accept a request.
REQ-007 The block SHALL have port req_cmd  in  2  00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data.
REQ-008 The block SHALL have port req_data  in  8  payload (address or write data; don't-care for rd-data).
REQ-009 The block SHALL have port rsp_valid  out  1  one-cycle pulse: read byte available.
REQ-010 The block SHALL have port rsp_data  out  8  read byte, held until the next rsp_valid.
REQ-011 The block SHALL have port busy  out  1  high whenever the state is not IDLE.
REQ-012 The block SHALL have port err  out  1  one-cycle pulse: request rejected (see Configuration).
REQ-013 The block SHALL have port SS_n  out  1  slave select, active-low, registered.
REQ-014 The block SHALL have port MOSI  out  1  serial data to slave, registered.
REQ-015 The block SHALL have port MISO  in  1  serial data from slave.

Function
REQ-016 The block SHALL implement states IDLE, SETUP, SHIFT, TURN, CAPTURE, GAP.
REQ-017 req_ready SHALL be 1 only in IDLE; a request is accepted at the edge where req_valid and req_ready are both 1 (cycle T).
REQ-018 At T+1 the block SHALL drive SS_n=0 with MOSI=0 (SETUP, one cycle).
REQ-019 From T+2 through T+12 the block SHALL drive 11 MOSI bits in SHIFT: req_cmd[1], then {req_cmd[1:0], req_data[7:0]} MSB first.
REQ-020 For cmd 00/01/10, at T+13 the block SHALL drive SS_n=1 and MOSI=0 and enter GAP; IDLE follows after GAP cycles.
REQ-021 For cmd 11, after SHIFT the block SHALL keep SS_n=0 for TURNAROUND cycles (TURN), then sample MISO on 8 consecutive edges (CAPTURE) MSB first.
REQ-022 For cmd 11, the cycle after the 8th sample the block SHALL assert rsp_valid for exactly one cycle with the byte on rsp_data, drive SS_n=1, and enter GAP.
REQ-023 Request fields SHALL be latched at acceptance; changes on req_* during a frame SHALL have no effect.
REQ-024 A request held valid while busy SHALL NOT be accepted early, dropped, or duplicated.
REQ-025 SS_n SHALL NOT glitch: exactly one low window per accepted request.

Reset
REQ-026 On rst=1 at an edge the block SHALL enter IDLE with SS_n=1, MOSI=0, rsp_valid=0, rsp_data=0, busy=0, err=0; req_ready=1 from the first post-reset cycle.
REQ-027 Reset mid-frame SHALL abort the frame (SS_n=1 next edge) and SHALL NOT produce rsp_valid for that frame.

Configuration
REQ-028 With macro SPI_MASTER_CMD_CHECK_EN defined, the block SHALL track protocol order: wr-data only after wr-addr, rd-data only after rd-addr; an out-of-order request SHALL be accepted, no frame sent, err pulsed at T+1, IDLE at T+1.
REQ-029 The order tracker SHALL clear on reset; rd-addr and wr-addr SHALL each re-arm their respective data command.
REQ-030 Without SPI_MASTER_CMD_CHECK_EN, every request SHALL be sent as given and err SHALL be tied 0.

Structure
REQ-031 Package spi_master_cmd_pkg SHALL hold: command encoding constants, state enum, FRAME_BITS=11, RD_BITS=8.
REQ-032 One sub-module spi_master_shreg SHALL implement the 11-bit load/shift-out and 8-bit shift-in registers with load, shift-enable and capture-enable controls.

Verification
REQ-033 Reset, then wr-addr 0xBB at T -> SS_n low T+1..T+12, MOSI=0,0,0,1,0,1,1,1,0,1,1 over T+2..T+12, SS_n high T+13, req_ready T+14.
REQ-034 wr-data 0xB9 then rd-addr 0xBB -> two frames separated by exactly GAP high cycles; MOSI sequences 0,0,1,10111001 and 1,1,0,10111011.
REQ-035 rd-data with slave model returning 0xB9 after TURNAROUND=2 -> rsp_valid single pulse at T+23, rsp_data=0xB9, SS_n low T+1..T+22.
REQ-036 rst asserted at T+6 of a rd-data frame -> SS_n=1 next edge, no rsp_valid, next request frames normally.
REQ-037 SPI_MASTER_CMD_CHECK_EN defined, rd-data after reset with no prior rd-addr -> err pulse at T+1, SS_n stays 1; same with the macro undefined -> frame sent, err=0.

Source files
------------

// File: rtl/spi_master_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_cmd_pkg
// Description : Shared command encodings, frame sizes and FSM states for the
//               SPI command master.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_master_cmd_pkg;

    localparam int FRAME_BITS = 11;
    localparam int RD_BITS    = 8;

    localparam logic [1:0] c_cmd_wr_addr = 2'b00;
    localparam logic [1:0] c_cmd_wr_data = 2'b01;
    localparam logic [1:0] c_cmd_rd_addr = 2'b10;
    localparam logic [1:0] c_cmd_rd_data = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_TURN    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_GAP     = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_master_shreg.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_shreg
// Description : 11-bit parallel-load / shift-out transmit register and 8-bit
//               shift-in receive register for the SPI command master.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_shreg
    import spi_master_cmd_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [FRAME_BITS-1:0] i_load_data,
    input  logic                  i_shift_en,
    input  logic                  i_cap_en,
    input  logic                  i_miso,
    output logic                  o_tx_msb,
    output logic [RD_BITS-1:0]    o_rx_next
);

    logic [FRAME_BITS-1:0] r_tx;
    logic [RD_BITS-2:0]    r_rx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx <= '0;
            r_rx <= '0;
        end else begin
            if (i_load) begin
                r_tx <= i_load_data;
            end else if (i_shift_en) begin
                r_tx <= {r_tx[FRAME_BITS-2:0], 1'b0};
            end
            if (i_cap_en) begin
                r_rx <= o_rx_next[RD_BITS-2:0];
            end
        end
    end

    assign o_tx_msb  = r_tx[FRAME_BITS-1];
    // Includes the live MISO bit so the final sample can go straight to the response
    assign o_rx_next = {r_rx, i_miso};

endmodule
`default_nettype wire

// File: rtl/spi_master_cmd.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_cmd
// Description : Command-driven SPI master sending 11-bit frames with optional
//               8-bit read-back. Define SPI_MASTER_CMD_CHECK_EN to enable
//               command-order checking with an err pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_cmd
    import spi_master_cmd_pkg::*;
#(
    parameter int TURNAROUND = 2,
    parameter int GAP        = 1
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_cmd,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       err,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    localparam logic [3:0] c_shift_last = 4'(FRAME_BITS - 1);
    localparam logic [3:0] c_turn_last  = 4'(TURNAROUND - 1);
    localparam logic [3:0] c_rd_last    = 4'(RD_BITS - 1);
    localparam logic [3:0] c_gap_last   = 4'(GAP - 1);

    state_t       r_state, w_state_next;
    logic [3:0]   r_cnt, w_cnt_next;
    logic [1:0]   r_cmd;
    logic         r_ss_n, w_ss_n_next;
    logic         r_mosi, w_mosi_next;
    logic         r_rsp_valid, w_rsp_valid_next;
    logic [7:0]   r_rsp_data;
    logic         r_err, w_err_next;
    logic         w_load, w_shift, w_cap;
    logic         w_order_ok;
    logic         w_tx_msb;
    logic [7:0]   w_rx_next;

`ifdef SPI_MASTER_CMD_CHECK_EN
    logic w_accept;
    logic r_wr_armed, r_rd_armed;

    assign w_accept = req_valid & req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_armed <= 1'b0;
            r_rd_armed <= 1'b0;
        end else if (w_accept) begin
            if (req_cmd == c_cmd_wr_addr) r_wr_armed <= 1'b1;
            if (req_cmd == c_cmd_rd_addr) r_rd_armed <= 1'b1;
        end
    end

    assign w_order_ok = (req_cmd == c_cmd_wr_data) ? r_wr_armed :
                        (req_cmd == c_cmd_rd_data) ? r_rd_armed : 1'b1;
`else
    assign w_order_ok = 1'b1;
`endif

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_ss_n_next      = r_ss_n;
        w_mosi_next      = r_mosi;
        w_rsp_valid_next = 1'b0;
        w_err_next       = 1'b0;
        w_load           = 1'b0;
        w_shift          = 1'b0;
        w_cap            = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (w_order_ok) begin
                        w_load       = 1'b1;
                        w_state_next = ST_SETUP;
                        w_ss_n_next  = 1'b0;
                        w_mosi_next  = 1'b0;
                    end else begin
                        // Rejected requests are consumed without touching the bus
                        w_err_next   = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                w_mosi_next  = w_tx_msb;
                w_shift      = 1'b1;
                w_cnt_next   = c_shift_last;
                w_state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (r_cnt == 4'd0) begin
                    w_mosi_next = 1'b0;
                    if (r_cmd == c_cmd_rd_data) begin
                        w_state_next = ST_TURN;
                        w_cnt_next   = c_turn_last;
                    end else begin
                        w_state_next = ST_GAP;
                        w_ss_n_next  = 1'b1;
                        w_cnt_next   = c_gap_last;
                    end
                end else begin
                    w_mosi_next = w_tx_msb;
                    w_shift     = 1'b1;
                    w_cnt_next  = r_cnt - 4'd1;
                end
            end
            ST_TURN: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = ST_CAPTURE;
                    w_cnt_next   = c_rd_last;
                end else begin
                    w_cnt_next   = r_cnt - 4'd1;
                end
            end
            ST_CAPTURE: begin
                w_cap = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_state_next     = ST_GAP;
                    w_ss_n_next      = 1'b1;
                    w_rsp_valid_next = 1'b1;
                    w_cnt_next       = c_gap_last;
                end else begin
                    w_cnt_next       = r_cnt - 4'd1;
                end
            end
            ST_GAP: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next   = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_ss_n_next  = 1'b1;
                w_mosi_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_cmd       <= 2'b00;
            r_ss_n      <= 1'b1;
            r_mosi      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 8'h00;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_ss_n      <= w_ss_n_next;
            r_mosi      <= w_mosi_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_err       <= w_err_next;
            if (w_load) r_cmd <= req_cmd;
            if (w_rsp_valid_next) r_rsp_data <= w_rx_next;
        end
    end

    spi_master_shreg u_shreg (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_load_data ({req_cmd[1], req_cmd, req_data}),
        .i_shift_en  (w_shift),
        .i_cap_en    (w_cap),
        .i_miso      (MISO),
        .o_tx_msb    (w_tx_msb),
        .o_rx_next   (w_rx_next)
    );

    assign req_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign SS_n      = r_ss_n;
    assign MOSI      = r_mosi;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_cmd.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master_cmd
// Description : Randomized self-checking bench for spi_master_cmd against a
//               cycle-indexed frame model; honours SPI_MASTER_CMD_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_cmd;

    localparam int TB_TURN = 2;
    localparam int TB_GAP  = 1;

    typedef struct packed {
        logic [1:0] cmd;
        logic [7:0] data;
        logic [7:0] rbyte;
    } req_t;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_cmd;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       err;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;

    int         n_tests;
    int         n_fail;
    logic [7:0] m_rsp;
    bit         m_wr_armed;
    bit         m_rd_armed;

    spi_master_cmd #(
        .TURNAROUND (TB_TURN),
        .GAP        (TB_GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (req_cmd),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .err       (err),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic req_t mk(input logic [1:0] c, input logic [7:0] d, input logic [7:0] rb);
        req_t r;
        r.cmd   = c;
        r.data  = d;
        r.rbyte = rb;
        return r;
    endfunction

    function automatic req_t rnd_req();
        return mk(2'($urandom), 8'($urandom), 8'($urandom));
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge where
    // req_ready is expected high again. Index k counts cycles after accept edge T.
    task automatic run_req(input req_t r, input bit hold, input req_t nxt);
        logic [10:0] bits;
        int          l_len;
        int          t_end;
        bit          ok;
        ok = 1'b1;
`ifdef SPI_MASTER_CMD_CHECK_EN
        if (r.cmd == 2'b01 && !m_wr_armed) ok = 1'b0;
        if (r.cmd == 2'b11 && !m_rd_armed) ok = 1'b0;
        if (r.cmd == 2'b00) m_wr_armed = 1'b1;
        if (r.cmd == 2'b10) m_rd_armed = 1'b1;
`endif
        req_valid = 1'b1;
        req_cmd   = r.cmd;
        req_data  = r.data;
        @(posedge clk);
        if (!ok) begin
            @(negedge clk);
            req_valid = 1'b0;
            check("err_pulse", err, 1);
            check("err_ss_n", SS_n, 1);
            check("err_ready", req_ready, 1);
            check("err_rsp_valid", rsp_valid, 0);
            @(negedge clk);
            check("err_clear", err, 0);
            check("err_ss_n2", SS_n, 1);
            return;
        end
        bits  = {r.cmd[1], r.cmd, r.data};
        l_len = (r.cmd == 2'b11) ? (12 + TB_TURN + 8) : 12;
        t_end = l_len + TB_GAP + 1;
        for (int k = 1; k <= t_end; k++) begin
            @(negedge clk);
            if (hold) begin
                if (k == 1) begin
                    req_cmd  = nxt.cmd;
                    req_data = nxt.data;
                end
            end else begin
                req_valid = 1'b0;
                req_cmd   = 2'($urandom);
                req_data  = 8'($urandom);
            end
            if (r.cmd == 2'b11 && k >= 13 + TB_TURN && k <= 20 + TB_TURN)
                MISO = r.rbyte[7 - (k - 13 - TB_TURN)];
            else
                MISO = 1'($urandom);
            check("ss_n", SS_n, (k <= l_len) ? 1'b0 : 1'b1);
            check("mosi", MOSI, (k >= 2 && k <= 12) ? bits[12 - k] : 1'b0);
            check("rsp_valid", rsp_valid, (r.cmd == 2'b11 && k == l_len + 1) ? 1'b1 : 1'b0);
            check("req_ready", req_ready, (k == t_end) ? 1'b1 : 1'b0);
            check("busy", busy, (k != t_end) ? 1'b1 : 1'b0);
            check("err_idle", err, 0);
            if (r.cmd == 2'b11 && k == l_len + 1) begin
                check("rsp_data", rsp_data, r.rbyte);
                m_rsp = r.rbyte;
            end
        end
        check("rsp_data_hold", rsp_data, m_rsp);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            MISO      = 1'($urandom);
            check("idle_ss_n", SS_n, 1);
            check("idle_ready", req_ready, 1);
            check("idle_rsp_valid", rsp_valid, 0);
        end
    endtask

    // Aborts a legal rd-data frame with rst sampled at edge T+6.
    task automatic reset_mid();
        req_valid = 1'b1;
        req_cmd   = 2'b11;
        req_data  = 8'($urandom);
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            MISO      = 1'($urandom);
            check("abort_ss_n_low", SS_n, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ss_n", SS_n, 1);
        check("abort_mosi", MOSI, 0);
        check("abort_busy", busy, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_rsp_data", rsp_data, 0);
        rst        = 1'b0;
        m_rsp      = 8'h00;
        m_wr_armed = 1'b0;
        m_rd_armed = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            MISO = 1'($urandom);
            check("abort_no_rsp", rsp_valid, 0);
            check("abort_ss_n_hi", SS_n, 1);
        end
    endtask

    initial begin
        req_t cur;
        req_t nxt;
        bit   h;
        n_tests    = 0;
        n_fail     = 0;
        m_rsp      = 8'h00;
        m_wr_armed = 1'b0;
        m_rd_armed = 1'b0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_cmd    = 2'b00;
        req_data   = 8'h00;
        MISO       = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ss_n", SS_n, 1);
        check("rst_mosi", MOSI, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", req_ready, 1);

        run_req(mk(2'b00, 8'hBB, 8'h00), 1'b0, mk(2'b00, 8'h00, 8'h00));
        run_req(mk(2'b01, 8'hB9, 8'h00), 1'b1, mk(2'b10, 8'hBB, 8'h00));
        run_req(mk(2'b10, 8'hBB, 8'h00), 1'b0, mk(2'b00, 8'h00, 8'h00));
        run_req(mk(2'b11, 8'h00, 8'hB9), 1'b0, mk(2'b00, 8'h00, 8'h00));

        reset_mid();
        run_req(mk(2'b11, 8'h3C, 8'h5A), 1'b0, mk(2'b00, 8'h00, 8'h00));
        run_req(mk(2'b10, 8'h11, 8'h00), 1'b0, mk(2'b00, 8'h00, 8'h00));
        run_req(mk(2'b11, 8'h22, 8'hC3), 1'b0, mk(2'b00, 8'h00, 8'h00));

        cur = rnd_req();
        for (int i = 0; i < 60; i++) begin
            nxt = rnd_req();
            h   = 1'($urandom);
            run_req(cur, h, nxt);
            if (!h) idle_cycles(int'($urandom_range(0, 2)));
            cur = nxt;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
